// File: rtl/mem_bus_bridge.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit external RAM bus,
// one beat per enabled halfword, with a per-beat valid timeout.
module mem_bus_bridge #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cs,
    output logic        we_n,
    output logic        re_n,
    output logic [1:0]  be_n,
    output logic [31:0] addro,
    output logic [15:0] datao,
    input  logic [15:0] datai,
    input  logic        valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Byte-lane mask for one halfword from its two enables
    function automatic logic [15:0] lane_mask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr & ~32'h3;
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (req_be[1:0] != 2'b00)      state_d = S_LO;
                    else if (req_be[3:2] != 2'b00) state_d = S_HI;
                    else                           state_d = S_DONE;
                end
            end
            S_LO: begin
                if (valid) begin
                    cnt_d = '0;
                    if (!we_q) rdata_d[15:0] = datai & lane_mask(be_q[1:0]);
                    state_d = (be_q[3:2] != 2'b00) ? S_GAP : S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: state_d = S_HI;
            S_HI: begin
                if (valid) begin
                    cnt_d = '0;
                    if (!we_q) rdata_d[31:16] = datai & lane_mask(be_q[3:2]);
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and response outputs decoded from registered state
    always_comb begin
        cs        = 1'b0;
        we_n      = 1'b1;
        re_n      = 1'b1;
        be_n      = 2'b11;
        addro     = '0;
        datao     = '0;
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid & err_q;
        if (state_q == S_LO) begin
            cs    = 1'b1;
            we_n  = ~we_q;
            re_n  = we_q;
            be_n  = ~be_q[1:0];
            addro = base_q;
            datao = wdata_q[15:0];
        end else if (state_q == S_HI) begin
            cs    = 1'b1;
            we_n  = ~we_q;
            re_n  = we_q;
            be_n  = ~be_q[3:2];
            addro = base_q + 32'd2;
            datao = wdata_q[31:16];
        end
    end

endmodule
